// File: rtl/oddeven_pkg.sv
// Shared definitions for the odd/even detector back end: FSM encoding and
// the layout of the handshake result word.
package oddeven_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_t;

   // The result word is {cnt_ovf, cnt_out}: the overflow flag sits above the count.
   localparam int RES_OVF_W = 1;

   function automatic int res_width(input int cnt_w);
      return cnt_w + RES_OVF_W;
   endfunction

endpackage

// File: rtl/z_event_window_counter_wrap.sv
// Modulo-MOD up counter with synchronous clear; last flags the terminal value
// so the parent can detect the end of a window without its own compare.
module wrap_counter #(
   parameter int MOD = 16,
   parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic         last
);

   localparam logic [W-1:0] LAST_VAL = W'(MOD - 1);

   logic [W-1:0] r_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (inc) begin
         r_q <= (r_q == LAST_VAL) ? '0 : r_q + W'(1);
      end
   end

   assign q    = r_q;
   assign last = (r_q == LAST_VAL);

endmodule

// File: rtl/z_event_window_counter.sv
// Counts detector pulses over fixed windows of WINDOW cycles and offers each
// window's saturating count, with an overflow flag, on a valid/ready output.
module z_event_window_counter
   import oddeven_pkg::*;
#(
   parameter int WINDOW = 16,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             z_in,
   output logic [CNT_W-1:0] cnt_out,
   output logic             cnt_ovf,
   output logic             cnt_valid,
   input  logic             cnt_ready,
   output logic             drop,
   output logic             busy
);

   localparam int WIN_W = $clog2(WINDOW);
   localparam int RES_W = res_width(CNT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t r_state;
   state_t w_state_next;

   logic             w_win_clr;
   logic             w_win_inc;
   logic             w_win_last;
   logic [WIN_W-1:0] w_win;
   logic             w_done;

   logic [CNT_W-1:0] r_evt;
   logic             r_sat;
   logic [CNT_W-1:0] w_evt_base;
   logic             w_sat_base;
   logic             w_at_max;
   logic [CNT_W-1:0] w_evt_next;
   logic             w_sat_next;

   logic [RES_W-1:0] r_result;
   logic             r_valid;
   logic             r_drop;

   wrap_counter #(
      .MOD (WINDOW),
      .W   (WIN_W)
   ) u_win_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_win_clr),
      .inc  (w_win_inc),
      .q    (w_win),
      .last (w_win_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_win_clr    = 1'b0;
      w_win_inc    = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_win_clr = 1'b1;
            if (en) begin
               w_state_next = ST_COUNT;
            end
         end
         ST_COUNT: begin
            w_win_inc = 1'b1;
            if (w_win_last) begin
               w_done = 1'b1;
               if (!en) begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // The first cycle of every window counts from zero, so back-to-back windows
   // never inherit the previous window's tally.
   always_comb begin
      w_evt_base = (w_win == '0) ? '0 : r_evt;
      w_sat_base = (w_win == '0) ? 1'b0 : r_sat;
      w_at_max   = (w_evt_base == CNT_MAX);
      w_evt_next = (z_in && !w_at_max) ? w_evt_base + CNT_W'(1) : w_evt_base;
      w_sat_next = w_sat_base | (z_in & w_at_max);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_evt <= '0;
         r_sat <= 1'b0;
      end else if (r_state != ST_COUNT || w_done) begin
         r_evt <= '0;
         r_sat <= 1'b0;
      end else begin
         r_evt <= w_evt_next;
         r_sat <= w_sat_next;
      end
   end

   // A held, unaccepted result wins over a newer one; the newer one is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_result <= '0;
         r_valid  <= 1'b0;
         r_drop   <= 1'b0;
      end else begin
         r_drop <= 1'b0;
         if (w_done) begin
            if (!r_valid || cnt_ready) begin
               r_result <= {w_sat_next, w_evt_next};
               r_valid  <= 1'b1;
            end else begin
               r_drop <= 1'b1;
            end
         end else if (r_valid && cnt_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign cnt_out   = r_result[CNT_W-1:0];
   assign cnt_ovf   = r_result[CNT_W];
   assign cnt_valid = r_valid;
   assign drop      = r_drop;
   assign busy      = (r_state == ST_COUNT);

endmodule
